// File: rtl/calc_disp_pkg.sv
// calc_disp_pkg: definitions shared by the binary-to-BCD converter and the
// display stage.
//   conv_state_t    - converter FSM states (IDLE / CONV / DONE)
//   DIGIT_ERR       - nibble rendered as a dash by the display stage
//   BCD_DIGITS      - number of BCD digits in the display word
//   MAX_VAL_DEFAULT - largest unsigned value that fits on BCD_DIGITS digits
//   NEG_MAX_MAG     - largest magnitude shown when digit3 carries the sign
package calc_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  localparam logic [3:0] DIGIT_ERR       = 4'hF;
  localparam int         BCD_DIGITS      = 4;
  localparam int         MAX_VAL_DEFAULT = 9999;
  localparam int         NEG_MAX_MAG     = 999;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble correction. A BCD digit of 5 or more gets
// 3 added so that the following left shift carries correctly into the next
// digit. Purely combinational.
//   din  - current BCD nibble
//   dout - corrected nibble (din + 3 when din >= 5, else din)
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // For legal digits (0..9) the corrected value is at most 12, so no carry
  // leaves the nibble. Out-of-range nibbles only occur for inputs that are
  // replaced by the error word anyway, so wrap-around there is harmless.
  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (double dabble, one bit
// per clock) feeding the display serializer.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous, active-high reset (aborts any conversion)
//   bin_in   - binary value, sampled only when a start is accepted
//   start    - conversion request, accepted while busy == 0
//   busy     - high while the shift/add engine is running
//   done     - one-cycle pulse when bcd_out/overflow are updated
//   bcd_out  - packed BCD, digit3 in [15:12] .. digit0 in [3:0]; held
//   overflow - last result did not fit; held with bcd_out
//
// Build option: define NEG_SIGN_EN to treat bin_in as two's complement. A
// negative value then shows its magnitude on digits 2..0 with DIGIT_ERR
// (dash) on digit3, and overflows when the magnitude exceeds 999.
//
// Latency from accepted start to done is IN_W+1 cycles, independent of the
// value or of an overflow. start is also accepted during the DONE cycle, so a
// held start gives one result every IN_W+1 cycles.
module bin_to_bcd_seq
  import calc_disp_pkg::*;
#(
  parameter int IN_W    = 14,
  parameter int MAX_VAL = MAX_VAL_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] bin_in,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [15:0]     bcd_out,
  output logic            overflow
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int SR_W  = IN_W + BCD_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(IN_W - 1);
  localparam logic [31:0]      MAX_VAL_U = 32'(MAX_VAL);
`ifdef NEG_SIGN_EN
  localparam logic [31:0]      NEG_MAX_U = 32'(NEG_MAX_MAG);
`endif

  conv_state_t      state;
  logic [SR_W-1:0]  sreg;
  logic [CNT_W-1:0] cnt;
  logic             ovf_flag;
  logic             neg_flag;

  // ------------------------------------------------------------------
  // Input qualification: magnitude, sign and range of the value to load.
  // ------------------------------------------------------------------
  logic [IN_W-1:0] in_mag;
  logic            in_neg;
  logic            in_ovf;

  always_comb begin
    in_mag = bin_in;
    in_neg = 1'b0;
    in_ovf = 1'b0;
`ifdef NEG_SIGN_EN
    in_neg = bin_in[IN_W-1];
    // The most-negative input negates to itself, which read unsigned is the
    // correct magnitude 2^(IN_W-1); it is then far above NEG_MAX_MAG.
    if (in_neg) begin
      in_mag = (~bin_in) + IN_W'(1);
      in_ovf = ({{(32-IN_W){1'b0}}, in_mag} > NEG_MAX_U);
    end else begin
      in_ovf = ({{(32-IN_W){1'b0}}, in_mag} > MAX_VAL_U);
    end
`else
    in_ovf = ({{(32-IN_W){1'b0}}, in_mag} > MAX_VAL_U);
`endif
  end

  // ------------------------------------------------------------------
  // CONV datapath: correct every BCD nibble, then shift the whole register.
  // ------------------------------------------------------------------
  logic [BCD_W-1:0] corr;
  logic [SR_W-1:0]  sreg_corr;

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .din  (sreg[IN_W + 4*gi +: 4]),
        .dout (corr[4*gi +: 4])
      );
    end
  endgenerate

  assign sreg_corr = {corr, sreg[IN_W-1:0]};

  // Final word presented on the DONE cycle.
  logic [15:0] result_bcd;

  always_comb begin
    if (ovf_flag) begin
      result_bcd = {BCD_DIGITS{DIGIT_ERR}};
    end else if (neg_flag) begin
      result_bcd = {DIGIT_ERR, sreg[SR_W-5 -: 12]};
    end else begin
      result_bcd = sreg[SR_W-1 -: 16];
    end
  end

  // ------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      neg_flag <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= 16'h0000;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg     <= {{BCD_W{1'b0}}, in_mag};
            cnt      <= '0;
            ovf_flag <= in_ovf;
            neg_flag <= in_neg;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end

        CONV: begin
          sreg <= sreg_corr << 1;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          bcd_out  <= result_bcd;
          overflow <= ovf_flag;
          done     <= 1'b1;
          // Relaunch in the same cycle so a held start sustains full
          // throughput; the flags read above are the old ones.
          if (start) begin
            sreg     <= {{BCD_W{1'b0}}, in_mag};
            cnt      <= '0;
            ovf_flag <= in_ovf;
            neg_flag <= in_neg;
            busy     <= 1'b1;
            state    <= CONV;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  localparam int IN_W = 14;
  localparam int LAT  = IN_W + 1;

  logic            clk;
  logic            rst;
  logic [IN_W-1:0] bin_in;
  logic            start;
  logic            busy;
  logic            done;
  logic [15:0]     bcd_out;
  logic            overflow;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.IN_W(IN_W), .MAX_VAL(9999)) dut (
    .clk      (clk),
    .rst      (rst),
    .bin_in   (bin_in),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: decimal digits by integer division, with the
  // range/sign rules applied directly to the numeric value.
  function automatic void ref_conv(input logic [IN_W-1:0] v,
                                   output logic [15:0] bcd,
                                   output logic ovf);
    int val;
    int mag;
    bit neg;
`ifdef NEG_SIGN_EN
    val = int'($signed(v));
`else
    val = int'(v);
`endif
    neg = (val < 0);
    mag = neg ? -val : val;
    if ((neg && mag > 999) || (!neg && mag > 9999)) begin
      bcd = 16'hFFFF;
      ovf = 1'b1;
    end else begin
      bcd[15:12] = neg ? 4'hF : 4'((mag / 1000) % 10);
      bcd[11:8]  = 4'((mag / 100) % 10);
      bcd[7:4]   = 4'((mag / 10) % 10);
      bcd[3:0]   = 4'(mag % 10);
      ovf = 1'b0;
    end
  endfunction

  // Launch one conversion and wait (bounded) for done. lat is the number of
  // clock edges from the accepting edge to the edge raising done, -1 on timeout.
  task automatic convert(input logic [IN_W-1:0] v, output logic [15:0] bcd,
                         output logic ovf, output int lat);
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bin_in = IN_W'($urandom);
    lat = -1;
    for (int k = 1; k <= 3 * LAT; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    bcd = bcd_out;
    ovf = overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, overflow, bcd_out} !== 19'd0) begin
      errors++;
      $display("FAIL reset_hold: busy=%b done=%b ovf=%b bcd=%h required 0 0 0 0000",
               busy, done, overflow, bcd_out);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, overflow, bcd_out} !== 19'd0) begin
      errors++;
      $display("FAIL reset_release: busy=%b done=%b ovf=%b bcd=%h required 0 0 0 0000",
               busy, done, overflow, bcd_out);
    end
    $display("reset: busy=%b done=%b ovf=%b bcd=%h", busy, done, overflow, bcd_out);
  endtask

  task automatic test_directed();
    logic [IN_W-1:0] vals[$];
    logic [15:0] bcd, exp_bcd;
    logic ovf, exp_ovf;
    int lat;
`ifdef NEG_SIGN_EN
    vals = '{14'd1234, 14'd0, 14'(-42), 14'(-999), 14'(-1000), 14'h2000, 14'd8191};
`else
    vals = '{14'd1234, 14'd0, 14'd9999, 14'd10000, 14'd16383, 14'd1};
`endif
    foreach (vals[i]) begin
      ref_conv(vals[i], exp_bcd, exp_ovf);
      convert(vals[i], bcd, ovf, lat);
      checks++;
      if (lat != LAT) begin
        errors++;
        $display("FAIL directed_latency: in=%0d latency=%0d required %0d", vals[i], lat, LAT);
      end
      checks++;
      if (bcd !== exp_bcd || ovf !== exp_ovf) begin
        errors++;
        $display("FAIL directed_value: in=%0d bcd=%h ovf=%b required %h %b",
                 vals[i], bcd, ovf, exp_bcd, exp_ovf);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL directed_done_width: in=%0d done=%b one cycle later required 0",
                 vals[i], done);
      end
      $display("directed: in=%0d bcd=%h ovf=%b latency=%0d", vals[i], bcd, ovf, lat);
    end
`ifndef NEG_SIGN_EN
    // Literal anchors from the plan, independent of the model.
    convert(14'd9999, bcd, ovf, lat);
    checks++;
    if (bcd !== 16'h9999 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL max_value: bcd=%h ovf=%b required 9999 0", bcd, ovf);
    end
    convert(14'd10000, bcd, ovf, lat);
    checks++;
    if (bcd !== 16'hFFFF || ovf !== 1'b1 || lat != LAT) begin
      errors++;
      $display("FAIL over_max: bcd=%h ovf=%b lat=%0d required ffff 1 %0d", bcd, ovf, lat, LAT);
    end
`else
    convert(14'(-42), bcd, ovf, lat);
    checks++;
    if (bcd !== 16'hF042 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL neg_42: bcd=%h ovf=%b required f042 0", bcd, ovf);
    end
`endif
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    int first_k = -1;
    logic [15:0] bcd_seen = '0;
    @(negedge clk);
    bin_in = 14'd42;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 3 * LAT; k++) begin
      if (k == 5) begin
        start  = 1'b1;
        bin_in = 14'd999;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_k < 0) begin
          first_k = k;
          bcd_seen = bcd_out;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 1 || first_k != LAT) begin
      errors++;
      $display("FAIL ignore_start_done: done_count=%0d at=%0d required 1 at %0d",
               ndone, first_k, LAT);
    end
    checks++;
    if (bcd_seen !== 16'h0042) begin
      errors++;
      $display("FAIL ignore_start_value: bcd=%h required 0042", bcd_seen);
    end
    $display("ignore_start: dones=%0d bcd=%h", ndone, bcd_seen);
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int k1 = -1, k2 = -1;
    logic [15:0] b1 = '0, b2 = '0;
    @(negedge clk);
    bin_in = 14'd7;
    start  = 1'b1;
    @(negedge clk);
    bin_in = 14'd8;
    for (int k = 1; k <= 4 * LAT; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          k1 = k; b1 = bcd_out; start = 1'b0;
        end else begin
          k2 = k; b2 = bcd_out;
          break;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 2 || k1 != LAT || k2 != 2 * LAT) begin
      errors++;
      $display("FAIL b2b_timing: dones=%0d at %0d,%0d required 2 at %0d,%0d",
               ndone, k1, k2, LAT, 2 * LAT);
    end
    checks++;
    if (b1 !== 16'h0007 || b2 !== 16'h0008) begin
      errors++;
      $display("FAIL b2b_value: bcd=%h,%h required 0007,0008", b1, b2);
    end
    $display("back_to_back: %h@%0d %h@%0d", b1, k1, b2, k2);
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    logic [15:0] bcd, exp_bcd;
    logic ovf, exp_ovf;
    int lat;
    @(negedge clk);
    bin_in = 14'd321;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, overflow, bcd_out} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid_abort: busy=%b done=%b ovf=%b bcd=%h required 0 0 0 0000",
               busy, done, overflow, bcd_out);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done: dones=%0d busy=%b required 0 0", ndone, busy);
    end
    ref_conv(14'd5678, exp_bcd, exp_ovf);
    convert(14'd5678, bcd, ovf, lat);
    checks++;
    if (bcd !== exp_bcd || ovf !== exp_ovf || lat != LAT) begin
      errors++;
      $display("FAIL reset_mid_restart: bcd=%h ovf=%b lat=%0d required %h %b %0d",
               bcd, ovf, lat, exp_bcd, exp_ovf, LAT);
    end
    $display("reset_mid: restart bcd=%h ovf=%b latency=%0d", bcd, ovf, lat);
  endtask

  // Held-start stream of boundary and random values; bin_in is changed
  // during each conversion to the next value to be sampled.
  task automatic test_random_stream();
    logic [IN_W-1:0] vals[$];
    logic [15:0] exp_bcd;
    logic exp_ovf;
    int k;
    vals = '{14'd9, 14'd10, 14'd99, 14'd100, 14'd999, 14'd1000, 14'd8191,
             14'd8192, 14'd9998, 14'd16383, 14'd7999};
    for (int i = 0; i < 300; i++) vals.push_back(IN_W'($urandom_range(0, 16383)));
    @(negedge clk);
    bin_in = vals[0];
    start  = 1'b1;
    @(negedge clk);
    bin_in = (vals.size() > 1) ? vals[1] : '0;
    for (int i = 0; i < vals.size(); i++) begin
      k = 0;
      while (k < 3 * LAT) begin
        @(negedge clk);
        k++;
        if (done) break;
      end
      if (i + 1 >= vals.size() - 1) start = 1'b0;
      ref_conv(vals[i], exp_bcd, exp_ovf);
      checks++;
      if (!done || k != LAT) begin
        errors++;
        $display("FAIL stream_latency: in=%0d latency=%0d required %0d", vals[i], done ? k : -1, LAT);
        start = 1'b0;
        break;
      end
      checks++;
      if (bcd_out !== exp_bcd || overflow !== exp_ovf) begin
        errors++;
        $display("FAIL stream_value: in=%0d bcd=%h ovf=%b required %h %b",
                 vals[i], bcd_out, overflow, exp_bcd, exp_ovf);
      end
      $display("stream: in=%0d bcd=%h ovf=%b", vals[i], bcd_out, overflow);
      if (i + 2 < vals.size()) bin_in = vals[i + 2];
    end
    start = 1'b0;
    repeat (2 * LAT) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
